// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, arbiter FSM encoding and the 32-bit word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response and RAM-side bundle of the memory arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      error;

    // slave is the arbiter's view, master is the requesters plus RAM.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, error
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, error
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of data grants issued while a fetch was waiting.
module arb_streak_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-port RAM between fetch and MEM; data wins unless the
// optional fetch fairness guard (macro ARB_FAIRNESS_EN) forces an instruction grant.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       error_q;
    logic       error_d;
    logic       dreq;
    logic       fetch_force;

    logic       ram_ren;
    logic       ram_wen;
    logic       ihit;
    logic       dhit;
    word_t      ram_addr;
    word_t      ram_store;
    word_t      iload;
    word_t      dload;

    assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_FAIRNESS_EN
    logic [STREAK_W-1:0] streak;
    logic                streak_inc;
    logic                streak_clr;

    assign streak_inc = (state_q == IDLE) && (state_d == DGNT) && bus.iREN;
    assign streak_clr = (state_q == IDLE) && ((state_d == IGNT) || !bus.iREN);

    arb_streak_counter #(
        .W (STREAK_W)
    ) u_streak (
        .CLK     (CLK),
        .RST     (RST),
        .inc_i   (streak_inc),
        .clr_i   (streak_clr),
        .count_o (streak)
    );

    assign fetch_force = bus.iREN && (streak == STREAK_W'(MAX_DSTREAK));
`else
    logic unused_max_dstreak;

    assign unused_max_dstreak = (MAX_DSTREAK != 0);
    assign fetch_force        = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    // A grant always returns to IDLE, giving one idle cycle between grants.
    always_comb begin
        state_d = state_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (dreq && !fetch_force) begin
                    state_d = DGNT;
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                if (bus.ramstate == ERROR) begin
                    error_d = 1'b1;
                end
                if (!bus.iREN || (bus.ramstate == ACCESS) || (bus.ramstate == ERROR)) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (bus.ramstate == ERROR) begin
                    error_d = 1'b1;
                end
                if (!dreq || (bus.ramstate == ACCESS) || (bus.ramstate == ERROR)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset held high abandons any grant in the same cycle.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        if (!RST) begin
            case (state_q)
                IGNT: begin
                    ram_ren  = bus.iREN;
                    ram_addr = bus.iaddr;
                    ihit     = bus.iREN && (bus.ramstate == ACCESS);
                end
                DGNT: begin
                    ram_wen   = bus.dWEN;
                    ram_ren   = bus.dREN & ~bus.dWEN;
                    ram_addr  = bus.daddr;
                    ram_store = bus.dstore;
                    dhit      = dreq && (bus.ramstate == ACCESS);
                end
                default: ;
            endcase
        end
        iload = ihit ? bus.ramload : '0;
        dload = dhit ? bus.ramload : '0;
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.ihit     = ihit;
    assign bus.dhit     = dhit;
    assign bus.iload    = iload;
    assign bus.dload    = dload;
    assign bus.error    = error_q;

endmodule
